// File: rtl/game_pkg.sv
// Shared types and helpers for the level countdown timer.
// Digits are BCD nibbles; anything above nine from upstream is treated as nine.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown: loads a clamped value, decrements on borrow.
// borrow_o is combinational so three instances form a ripple borrow chain.
module bcd_digit_down
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_en_i,
  input  logic       borrow_i,
  output logic [3:0] value_o,
  output logic       borrow_o
);

  bcd_digit_t value_q;
  bcd_digit_t value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (dec_en_i && borrow_i) begin
      value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign borrow_o = (value_q == 4'd0) && borrow_i;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Per-level countdown: latches three BCD digits on load, counts down once per
// second while running, and pulses time_up for one cycle when 000 is reached.
module bcd_countdown_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_W = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic [3:0] load_three,
  input  logic [3:0] load_two,
  input  logic [3:0] load_one,
  output logic [3:0] value_three,
  output logic [3:0] value_two,
  output logic [3:0] value_one,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  localparam logic [TICK_W-1:0] TICK_TERM = TICK_W'(CLK_HZ - 1);

  timer_state_t      state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              time_up_q, time_up_d;

  logic [3:0] ld_three, ld_two, ld_one;
  logic       load_zero;
  logic       sec_tick;
  logic       tick_apply;
  logic       count_is_one;
  logic       borrow_one, borrow_two, borrow_three;

  assign ld_three  = clamp_bcd(load_three);
  assign ld_two    = clamp_bcd(load_two);
  assign ld_one    = clamp_bcd(load_one);
  assign load_zero = (ld_three == 4'd0) && (ld_two == 4'd0) && (ld_one == 4'd0);

  assign sec_tick     = (state_q == RUN) && (presc_q == TICK_TERM);
  assign count_is_one = (value_three == 4'd0) && (value_two == 4'd0) && (value_one == 4'd1);

  // borrow_three high means the whole count is already 000: never underflow.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    time_up_d  = 1'b0;
    tick_apply = 1'b0;
    if (load) begin
      presc_d = '0;
      if (load_zero) begin
        state_d   = EXPIRED;
        time_up_d = (state_q != EXPIRED);
      end else begin
        state_d = run ? RUN : PAUSE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          presc_d    = sec_tick ? '0 : presc_q + TICK_W'(1);
          tick_apply = sec_tick && !borrow_three;
          if (tick_apply && count_is_one) begin
            state_d   = EXPIRED;
            time_up_d = 1'b1;
          end else if (!run) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (run) begin
            state_d = RUN;
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_up_q <= time_up_d;
    end
  end

  // Ones digit always sees a borrow request; tick_apply gates the whole chain.
  bcd_digit_down u_digit_one (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (ld_one),
    .dec_en_i   (tick_apply),
    .borrow_i   (1'b1),
    .value_o    (value_one),
    .borrow_o   (borrow_one)
  );

  bcd_digit_down u_digit_two (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (ld_two),
    .dec_en_i   (tick_apply),
    .borrow_i   (borrow_one),
    .value_o    (value_two),
    .borrow_o   (borrow_two)
  );

  bcd_digit_down u_digit_three (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .load_val_i (ld_three),
    .dec_en_i   (tick_apply),
    .borrow_i   (borrow_two),
    .value_o    (value_three),
    .borrow_o   (borrow_three)
  );

  assign running = (state_q == RUN);
  assign expired = (state_q == EXPIRED);
  assign time_up = time_up_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: decimal-count reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_bcd_countdown_timer;

  localparam int CLK_HZ = 4;
  localparam int TICK_W = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clk;
  logic       reset;
  logic       load;
  logic       run;
  logic [3:0] load_three, load_two, load_one;
  logic [3:0] value_three, value_two, value_one;
  logic       running, expired, time_up;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Reference model: count held as a plain decimal integer.
  int m_count = 0;
  int m_mode  = M_IDLE;
  int m_phase = 0;
  bit m_pulse = 1'b0;
  bit tu_prev = 1'b0;

  bcd_countdown_timer #(
    .CLK_HZ (CLK_HZ),
    .TICK_W (TICK_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .run         (run),
    .load_three  (load_three),
    .load_two    (load_two),
    .load_one    (load_one),
    .value_three (value_three),
    .value_two   (value_two),
    .value_one   (value_one),
    .running     (running),
    .expired     (expired),
    .time_up     (time_up)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int min9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [11:0] to_bcd(input int c);
    logic [11:0] r;
    r[11:8] = 4'(c / 100);
    r[7:4]  = 4'((c / 10) % 10);
    r[3:0]  = 4'(c % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int c;
    m_pulse = 1'b0;
    if (reset) begin
      m_count = 0;
      m_mode  = M_IDLE;
      m_phase = 0;
    end else if (load) begin
      c = 100 * min9(load_three) + 10 * min9(load_two) + min9(load_one);
      m_phase = 0;
      m_count = c;
      if (c == 0) begin
        m_pulse = (m_mode != M_EXP);
        m_mode  = M_EXP;
      end else begin
        m_mode = run ? M_RUN : M_PAUSE;
      end
    end else if (m_mode == M_RUN) begin
      if (m_phase == CLK_HZ - 1) begin
        m_phase = 0;
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_mode  = M_EXP;
          m_pulse = 1'b1;
        end else if (!run) begin
          m_mode = M_PAUSE;
        end
      end else begin
        m_phase++;
        if (!run) m_mode = M_PAUSE;
      end
    end else if (m_mode == M_PAUSE && run) begin
      m_mode = M_RUN;
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (check_en) begin
      check("model_digits", {20'd0, value_three, value_two, value_one}, {20'd0, to_bcd(m_count)});
      check("model_running", {31'd0, running}, {31'd0, m_mode == M_RUN});
      check("model_expired", {31'd0, expired}, {31'd0, m_mode == M_EXP});
      check("model_time_up", {31'd0, time_up}, {31'd0, m_pulse});
      check("time_up_gap", {31'd0, time_up & tu_prev}, 32'd0);
      tu_prev = time_up;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o, input logic r);
    load_three = h;
    load_two   = t;
    load_one   = o;
    run        = r;
    load       = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic check_digits(input string name, input logic [11:0] exp);
    check(name, {20'd0, value_three, value_two, value_one}, {20'd0, exp});
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; run = 1'b0;
    load_three = 4'd0; load_two = 4'd0; load_one = 4'd0;
    step(2);
    check_en = 1'b1;
    reset = 1'b0;
    check_digits("reset_digits", 12'h000);
    check("reset_flags", {29'd0, running, expired, time_up}, 32'd0);

    // 1: basic countdown to expiry
    do_load(4'd0, 4'd1, 4'd0, 1'b1);
    check_digits("t1_load", 12'h010);
    check("t1_running", {31'd0, running}, 32'd1);
    step(3);
    check_digits("t1_before_tick", 12'h010);
    step(1);
    check_digits("t1_first_dec", 12'h009);
    step(35);
    check_digits("t1_at_001", 12'h001);
    check("t1_no_pulse_yet", {31'd0, time_up}, 32'd0);
    step(1);
    check_digits("t1_zero", 12'h000);
    check("t1_pulse", {30'd0, expired, time_up}, 32'd3);
    check("t1_not_running", {31'd0, running}, 32'd0);
    run = 1'b0;
    step(1);
    check("t1_pulse_ends", {30'd0, expired, time_up}, 32'd2);
    run = 1'b1;
    step(6);
    check("t1_still_expired", {30'd0, expired, running}, 32'd2);

    // 2: borrow across two digits
    do_load(4'd1, 4'd0, 4'd0, 1'b1);
    step(4);
    check_digits("t2_borrow", 12'h099);
    step(4);
    check_digits("t2_next", 12'h098);

    // 3: pause holds the prescaler
    do_load(4'd0, 4'd0, 4'd5, 1'b1);
    step(2);
    run = 1'b0;
    step(10);
    check_digits("t3_paused", 12'h005);
    check("t3_not_running", {31'd0, running}, 32'd0);
    run = 1'b1;
    step(1);
    check_digits("t3_resume", 12'h005);
    step(1);
    check_digits("t3_dec_after_resume", 12'h004);

    // 4: clamp and zero load
    do_load(4'hC, 4'hA, 4'd3, 1'b1);
    check_digits("t4_clamp", 12'h993);
    do_load(4'd0, 4'd0, 4'd0, 1'b1);
    check_digits("t4_zero_digits", 12'h000);
    check("t4_zero_flags", {29'd0, running, expired, time_up}, 32'd3);
    step(1);
    check("t4_zero_pulse_ends", {31'd0, time_up}, 32'd0);

    // 5: load on the final tick wins
    do_load(4'd0, 4'd0, 4'd1, 1'b1);
    step(3);
    do_load(4'd0, 4'd2, 4'd0, 1'b1);
    check_digits("t5_collide", 12'h020);
    check("t5_no_pulse", {29'd0, running, expired, time_up}, 32'd4);
    step(3);
    check_digits("t5_presc_cleared", 12'h020);
    step(1);
    check_digits("t5_dec", 12'h019);

    // 6: reset mid-count
    do_load(4'd0, 4'd3, 4'd7, 1'b1);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_digits("t6_reset_digits", 12'h000);
    check("t6_reset_flags", {29'd0, running, expired, time_up}, 32'd0);
    run = 1'b1;
    step(10);
    check_digits("t6_idle_holds", 12'h000);
    check("t6_idle_flags", {29'd0, running, expired, time_up}, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      run   = ($urandom_range(0, 99) < 85);
      load  = ($urandom_range(0, 59) == 0);
      load_three = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      load_two   = 4'($urandom_range(0, 2));
      load_one   = 4'($urandom_range(0, 15));
      step(1);
    end
    reset = 1'b0;
    load  = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
